codificador_decimal_150: RTL and testbench
==========================================

// Module: codificador_decimal_150
// PURPOSE
//  Sequential decimal-entry encoder: accepts BCD digits MSD-first from switches/keypad, accumulates binary.
//  On enter, the 8-bit binary value (0..MAX_VAL) is presented on a valid/ready output.
//  Reverse path of the binary->3-digit 7-seg display chain.
//  acc_preview can feed that display chain for live echo.
// PARAMETERS
//  W          8    width of binary result and accumulator
//  MAX_VAL    150  largest legal committed value; any partial value above it is an error
//  NUM_DIGITS 3    maximum digits per entry
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  digit_valid  in   1   one-cycle strobe: digit is sampled this edge
//  digit        in   4   BCD digit, legal 0..9
//  enter        in   1   one-cycle strobe: commit current entry
//  clear        in   1   one-cycle strobe: abort entry / clear error
//  num_out      out  W   committed binary value, stable while num_valid=1
//  num_valid    out  1   committed value available
//  num_ready    in   1   consumer accepts num_out when num_valid&&num_ready
//  acc_preview  out  W   running accumulator, for display echo
//  digit_count  out  2   digits accepted in current entry (0..NUM_DIGITS)
//  err          out  1   sticky error: illegal digit or value > MAX_VAL
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; num_out=0, num_valid=0, acc_preview=0, digit_count=0, err=0.
//  FSM states: IDLE (count=0), ENTRY (1..NUM_DIGITS digits held), HOLD (num_valid=1), ERROR (err=1).
//  Arithmetic: nxt = acc*10 + digit, computed W+4 bits wide (no truncation before compare).
//  Digit accept (IDLE/ENTRY, digit_valid=1, count<NUM_DIGITS):
//   - digit>9 -> ERROR.
//   - nxt>MAX_VAL -> ERROR.
//   - else acc<=nxt[W-1:0], count++, state ENTRY.
//  Update latency: acc_preview/digit_count update on the same edge; visible the next cycle.
//  Digit when count==NUM_DIGITS: ignored, no state change, no error.
//  Leading zeros are accepted and counted ("0","0","7" -> 7).
//  enter in IDLE (no digits): ignored. enter in ENTRY -> HOLD:
//   - num_out<=acc and num_valid<=1 on that edge (1-cycle latency from enter).
//  enter+digit_valid same cycle in ENTRY: enter wins; digit discarded.
//  HOLD: digit_valid/enter ignored; num_out and num_valid held.
//   - On edge with num_ready=1: num_valid<=0, acc<=0, count<=0, state IDLE.
//   - num_ready while num_valid=0: no effect.
//  ERROR: err=1, acc_preview frozen at last legal value, all inputs except clear ignored.
//  clear: highest priority in every state, over enter/digit/num_ready.
//   - Next edge: IDLE, acc=0, count=0, err=0, num_valid=0; num_out keeps last value.
//  Reset asserted mid-entry or in HOLD: immediate return to reset values; pending result lost.
// CONFIGURATION
//  AUTO_COMMIT_EN defined:
//   - The digit accept that makes count==NUM_DIGITS also commits: same edge -> HOLD, num_out=nxt, num_valid=1.
//   - enter still commits shorter entries.
//  AUTO_COMMIT_EN undefined:
//   - Full entry stays in ENTRY awaiting enter; extra digits ignored as above.
// TESTING
//  1. Digits 1,2,5 then enter:
//     - num_valid=1, num_out=125 one cycle after enter.
//     - num_ready low 3 cycles -> held.
//     - num_ready=1 -> IDLE, acc_preview=0.
//  2. Digits 1,5,1 -> err=1 after third digit, acc_preview stays 15.
//     enter ignored; clear -> err=0, digit_count=0.
//  3. digit=4'hA with digit_valid -> err=1 next cycle. Digits 1,5,0, enter -> num_out=150 (boundary legal).
//  4. enter with no digits -> no num_valid. Digit 7, enter -> num_out=7.
//     Digit 3 with enter same cycle -> num_out=0? no: digit dropped, result = prior acc.
//  5. Digits 1,2 then rst_n=0 mid-cycle -> all outputs 0 immediately.
//     Clear during HOLD -> num_valid=0 next cycle.
//  6. Digits 1,0,0:
//     - AUTO_COMMIT_EN defined: num_valid=1, num_out=100 without enter.
//     - AUTO_COMMIT_EN undefined: 4th digit 9 ignored; enter -> num_out=100.

Source files
------------

// File: rtl/codificador_decimal_150.sv
// rtl/codificador_decimal_150.sv - BCD keypad digits to binary value with valid/ready commit (option: AUTO_COMMIT_EN)
module codificador_decimal_150 #(
  parameter int W          = 8,
  parameter int MAX_VAL    = 150,
  parameter int NUM_DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         digit_valid,
  input  logic [3:0]   digit,
  input  logic         enter,
  input  logic         clear,
  output logic [W-1:0] num_out,
  output logic         num_valid,
  input  logic         num_ready,
  output logic [W-1:0] acc_preview,
  output logic [1:0]   digit_count,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // Extra 4 bits keep acc*10+digit exact so the range check sees the true value.
  localparam int             XW       = W + 4;
  localparam logic [XW-1:0]  MAX_X    = XW'(MAX_VAL);
  localparam logic [1:0]     FULL_CNT = 2'(NUM_DIGITS);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [1:0]     count_q, count_d;
  logic [W-1:0]   num_out_q, num_out_d;
  logic           num_valid_q, num_valid_d;

  logic [XW-1:0]  nxt;
  logic           digit_legal;
  logic           has_room;
  logic           in_range;

  assign nxt         = ({4'b0000, acc_q} * XW'(10)) + {{W{1'b0}}, digit};
  assign digit_legal = (digit <= 4'd9);
  assign has_room    = (count_q < FULL_CNT);
  assign in_range    = (nxt <= MAX_X);

  // State register: all entry, result and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      num_out_q   <= '0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      num_out_q   <= num_out_d;
      num_valid_q <= num_valid_d;
    end
  end

  // Next-state logic: clear beats everything, enter beats a same-cycle digit.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    num_out_d   = num_out_q;
    num_valid_d = num_valid_q;

    if (clear) begin
      state_d     = S_IDLE;
      acc_d       = '0;
      count_d     = '0;
      num_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (enter && (state_q == S_ENTRY)) begin
            state_d     = S_HOLD;
            num_out_d   = acc_q;
            num_valid_d = 1'b1;
          end else if (digit_valid && has_room) begin
            if (!digit_legal || !in_range) begin
              // acc stays at the last legal value so the echo freezes there.
              state_d = S_ERROR;
            end else begin
              acc_d   = nxt[W-1:0];
              count_d = count_q + 2'd1;
              state_d = S_ENTRY;
`ifdef AUTO_COMMIT_EN
              if ((count_q + 2'd1) == FULL_CNT) begin
                state_d     = S_HOLD;
                num_out_d   = nxt[W-1:0];
                num_valid_d = 1'b1;
              end
`endif
            end
          end
        end
        S_HOLD: begin
          if (num_ready) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            count_d     = '0;
            num_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_ERROR;
        end
      endcase
    end
  end

  // Output logic: registered values straight out, err decoded from state.
  always_comb begin
    num_out     = num_out_q;
    num_valid   = num_valid_q;
    acc_preview = acc_q;
    digit_count = count_q;
    err         = (state_q == S_ERROR);
  end

endmodule

// File: tb/tb_codificador_decimal_150.sv
// tb/tb_codificador_decimal_150.sv - directed self-checking bench for codificador_decimal_150
module tb_codificador_decimal_150;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [7:0] num_out;
  logic       num_valid;
  logic       num_ready;
  logic [7:0] acc_preview;
  logic [1:0] digit_count;
  logic       err;

  int errors = 0;
  int checks = 0;

  codificador_decimal_150 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
    .num_out     (num_out),
    .num_valid   (num_valid),
    .num_ready   (num_ready),
    .acc_preview (acc_preview),
    .digit_count (digit_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic accept();
    num_ready = 1'b1;
    tick();
    num_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    enter       = 1'b0;
    clear       = 1'b0;
    num_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_num_out", num_out, 0);
    chk("rst_num_valid", num_valid, 0);
    chk("rst_acc", acc_preview, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // 1: 1,2,5 enter -> 125, held while not ready
    key(4'd1);
    chk("t1_acc1", acc_preview, 1);
    key(4'd2);
    chk("t1_acc12", acc_preview, 12);
    key(4'd5);
    chk("t1_acc125", acc_preview, 125);
    chk("t1_count3", digit_count, 3);
    chk("t1_novalid_before_enter", num_valid, 0);
    press_enter();
    chk("t1_valid", num_valid, 1);
    chk("t1_num", num_out, 125);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold_valid", num_valid, 1);
      chk("t1_hold_num", num_out, 125);
    end
    accept();
    chk("t1_done_valid", num_valid, 0);
    chk("t1_done_acc", acc_preview, 0);
    chk("t1_done_count", digit_count, 0);

    // 2: 1,5,1 overflows -> error, preview frozen at 15
    key(4'd1);
    key(4'd5);
    key(4'd1);
    chk("t2_err", err, 1);
    chk("t2_acc_frozen", acc_preview, 15);
    chk("t2_count_frozen", digit_count, 2);
    press_enter();
    chk("t2_enter_ignored_valid", num_valid, 0);
    chk("t2_enter_ignored_err", err, 1);
    press_clear();
    chk("t2_clear_err", err, 0);
    chk("t2_clear_count", digit_count, 0);
    chk("t2_clear_acc", acc_preview, 0);

    // 3: illegal digit, then 150 boundary
    key(4'hA);
    chk("t3_bad_digit_err", err, 1);
    press_clear();
    key(4'd1);
    key(4'd5);
    key(4'd0);
    chk("t3_acc150", acc_preview, 150);
    chk("t3_no_err", err, 0);
    press_enter();
    chk("t3_valid", num_valid, 1);
    chk("t3_num150", num_out, 150);
    accept();

    // 4: enter with no digits ignored; single digit; enter beats digit
    press_enter();
    chk("t4_empty_enter", num_valid, 0);
    key(4'd7);
    press_enter();
    chk("t4_num7", num_out, 7);
    chk("t4_valid7", num_valid, 1);
    accept();
    key(4'd4);
    digit_valid = 1'b1;
    digit       = 4'd3;
    press_enter();
    digit_valid = 1'b0;
    digit       = 4'd0;
    chk("t4_enter_wins_num", num_out, 4);
    chk("t4_enter_wins_count", digit_count, 1);
    accept();

    // num_ready while nothing valid does nothing
    key(4'd2);
    accept();
    chk("t4_stray_ready_acc", acc_preview, 2);
    press_clear();

    // 5: async reset mid-entry, clear during HOLD
    key(4'd1);
    key(4'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_acc", acc_preview, 0);
    chk("t5_async_count", digit_count, 0);
    chk("t5_async_num", num_out, 0);
    #1;
    rst_n = 1'b1;
    tick();
    key(4'd9);
    press_enter();
    chk("t5_hold_valid", num_valid, 1);
    press_clear();
    chk("t5_clear_hold_valid", num_valid, 0);
    chk("t5_clear_keeps_num", num_out, 9);

    // 6: full three-digit entry 1,0,0
    key(4'd1);
    key(4'd0);
    key(4'd0);
`ifdef AUTO_COMMIT_EN
    chk("t6_auto_valid", num_valid, 1);
    chk("t6_auto_num", num_out, 100);
`else
    chk("t6_wait_valid", num_valid, 0);
    chk("t6_count3", digit_count, 3);
    key(4'd9);
    chk("t6_extra_acc", acc_preview, 100);
    chk("t6_extra_count", digit_count, 3);
    chk("t6_extra_err", err, 0);
    press_enter();
    chk("t6_enter_valid", num_valid, 1);
    chk("t6_enter_num", num_out, 100);
`endif
    accept();
    chk("t6_released", num_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
